// File: rtl/ft245_reg_bridge.sv
// Parses host packets from the FT245 RX FIFO into register-bus writes and reads, and returns read responses through the TX FIFO.
// Optional packet checksums are enabled by defining FT245_CSUM_EN.
module ft245_reg_bridge #(
  parameter logic [7:0] SYNC_BYTE = 8'h55,
  parameter logic [7:0] RESP_BYTE = 8'hAA,
  parameter int         ERR_W     = 8,
  parameter int         TIMEOUT   = 50000
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_rdata,
  input  logic             rx_rempty,
  output logic             rx_rinc,
  output logic [7:0]       tx_wdata,
  input  logic             tx_wfull,
  output logic             tx_winc,
  output logic [7:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata,
  output logic [ERR_W-1:0] err_cnt,
  output logic             busy
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    HUNT, CMD, ADDR, DATA, EXEC, RDWAIT, RESP_HDR, RESP_ADDR, RESP_DATA
`ifdef FT245_CSUM_EN
    , CSUM, RESP_CSUM
`endif
  } state_t;

`ifdef FT245_CSUM_EN
  localparam state_t RX_DONE = CSUM;
  localparam state_t TX_DONE = RESP_CSUM;
`else
  localparam state_t RX_DONE = EXEC;
  localparam state_t TX_DONE = HUNT;
`endif

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             rd_q, rd_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             err_evt;
  logic             parse;
`ifdef FT245_CSUM_EN
  logic [7:0]       sum_q, sum_d;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    tmo_d    = '0;
    err_evt  = 1'b0;
    parse    = 1'b0;
    rx_rinc  = 1'b0;
    tx_winc  = 1'b0;
    tx_wdata = '0;
    reg_we   = 1'b0;
    reg_re   = 1'b0;
`ifdef FT245_CSUM_EN
    sum_d    = sum_q;
`endif
    case (state_q)
      HUNT: begin
        rx_rinc = !rx_rempty;
        if (rx_rinc && rx_rdata == SYNC_BYTE) state_d = CMD;
      end
      CMD: begin
        parse = 1'b1;
        if (!rx_rempty) begin
          rx_rinc = 1'b1;
`ifdef FT245_CSUM_EN
          sum_d = rx_rdata;
`endif
          if (rx_rdata == 8'h01 || rx_rdata == 8'h02) begin
            rd_d    = (rx_rdata == 8'h02);
            state_d = ADDR;
          end else begin
            err_evt = 1'b1;
            state_d = HUNT;
          end
        end
      end
      ADDR: begin
        parse = 1'b1;
        if (!rx_rempty) begin
          rx_rinc = 1'b1;
          addr_d  = rx_rdata;
`ifdef FT245_CSUM_EN
          sum_d = sum_q + rx_rdata;
`endif
          state_d = rd_q ? RX_DONE : DATA;
        end
      end
      DATA: begin
        parse = 1'b1;
        if (!rx_rempty) begin
          rx_rinc = 1'b1;
          wdata_d = rx_rdata;
`ifdef FT245_CSUM_EN
          sum_d = sum_q + rx_rdata;
`endif
          state_d = RX_DONE;
        end
      end
`ifdef FT245_CSUM_EN
      CSUM: begin
        parse = 1'b1;
        if (!rx_rempty) begin
          rx_rinc = 1'b1;
          if (rx_rdata == sum_q) begin
            state_d = EXEC;
          end else begin
            err_evt = 1'b1;
            state_d = HUNT;
          end
        end
      end
`endif
      EXEC: begin
        reg_we  = !rd_q;
        reg_re  = rd_q;
        state_d = rd_q ? RDWAIT : HUNT;
      end
      // Register bus returns read data exactly one cycle after the strobe.
      RDWAIT: begin
        rdata_d = reg_rdata;
        state_d = RESP_HDR;
      end
      RESP_HDR: begin
        tx_wdata = RESP_BYTE;
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = RESP_ADDR;
      end
      RESP_ADDR: begin
        tx_wdata = addr_q;
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = RESP_DATA;
      end
      RESP_DATA: begin
        tx_wdata = rdata_q;
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = TX_DONE;
      end
`ifdef FT245_CSUM_EN
      RESP_CSUM: begin
        tx_wdata = addr_q + rdata_q;
        tx_winc  = !tx_wfull;
        if (tx_winc) state_d = HUNT;
      end
`endif
      default: state_d = HUNT;
    endcase

    // Inter-byte timeout: a popped byte leaves tmo_d at its cleared default.
    if (parse && !rx_rinc) begin
      if (tmo_q == TMO_LAST) begin
        err_evt = 1'b1;
        state_d = HUNT;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    err_d = (err_evt && err_q != '1) ? err_q + 1'b1 : err_q;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      tmo_q   <= '0;
      err_q   <= '0;
`ifdef FT245_CSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`ifdef FT245_CSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q != HUNT);

endmodule
